// File: rtl/inverse_processing_unit_1d_pkg.sv
// Shared types and fixed-point helpers for the inverse 9/7 column lifting unit.
package inverse_processing_unit_1d_pkg;

  localparam real AlphaDefault = -1.586134342;
  localparam real BetaDefault  = -0.052980118;

  typedef enum logic [1:0] {IDLE, FIRST, STEADY, FLUSH} state_e;

  // Round-half-away-from-zero conversion of a real coefficient to Q.point.
  function automatic int to_fixed(real v, int point);
    real scale;
    real s;
    scale = 1.0;
    for (int i = 0; i < point; i++) scale = scale * 2.0;
    s = v * scale;
    if (s >= 0.0) return $rtoi(s + 0.5);
    else return -$rtoi(0.5 - s);
  endfunction

  function automatic longint mul_shift(longint k, longint x, int point);
    return (k * x) >>> point;
  endfunction

endpackage

// File: rtl/inverse_lifting_step.sv
// One inverse lifting step: y = a - k*(b + c), optionally registered.
module inverse_lifting_step
  import inverse_processing_unit_1d_pkg::*;
#(
  parameter int DataWidth  = 16,
  parameter int Point      = 10,
  parameter int Coef       = 0,
  parameter bit Registered = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [DataWidth-1:0] c_i,
  output logic [DataWidth-1:0] y_o
);

  logic [DataWidth-1:0] sum;
  logic [DataWidth-1:0] prod;
  logic [DataWidth-1:0] diff;
  longint               prod_full;
  logic                 unused_hi;

  // Sum wraps at DataWidth before the full-precision product and floor shift.
  assign sum       = b_i + c_i;
  assign prod_full = mul_shift(longint'(Coef), longint'($signed(sum)), Point);
  assign prod      = prod_full[DataWidth-1:0];
  assign diff      = a_i - prod;
  assign unused_hi = ^prod_full[63:DataWidth];

  generate
    if (Registered) begin : g_reg
      logic [DataWidth-1:0] y_q;
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) y_q <= '0;
        else if (en_i) y_q <= diff;
      end
      assign y_o = y_q;
    end else begin : g_comb
      logic unused_ctl;
      assign unused_ctl = clk_i ^ rst_i ^ en_i;
      assign y_o        = diff;
    end
  endgenerate

endmodule

// File: rtl/inverse_processing_unit_1d.sv
// Inverse 9/7 lifting, column direction: undoes update then predict with
// per-column line buffers; output trails input by one row-pair plus a flush row.
module inverse_processing_unit_1d
  import inverse_processing_unit_1d_pkg::*;
#(
  parameter int  DataWidth       = 16,
  parameter int  Point           = 10,
  parameter int  MaximumSideSize = 512,
  parameter real Alpha           = AlphaDefault,
  parameter real Beta            = BetaDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic                   s_eof_i,
  input  logic [2*DataWidth-1:0] s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic                   m_eof_o,
  output logic [2*DataWidth-1:0] m_data_o
);

  localparam int AddrWidth = $clog2(MaximumSideSize);
  localparam int IntAlpha  = to_fixed(Alpha, Point);
  localparam int IntBeta   = to_fixed(Beta, Point);

  state_e                 state_q;
  logic [AddrWidth-1:0]   col_q, last_col_q;
  logic                   drop_q, sof_pend_q;
  logic                   adv, acc, restart, in_beat, beat, first_beat, flush_beat, line_end;
  logic [AddrWidth-1:0]   beat_col_d;
  logic [DataWidth-1:0]   h_in, l_in;

  logic                   s1_valid_q, s1_first_q, s1_flush_q;
  logic [AddrWidth-1:0]   s1_col_q;
  logic [DataWidth-1:0]   s1_l_q, s1_h_q, hprev_q, eprev_q;
  logic                   s1_emit, e_we;
  logic [DataWidth-1:0]   even_b, x_even, odd_c, m_odd;

  logic                   m_valid_q, m_sof_q, m_eol_q, m_eof_q;
  logic [DataWidth-1:0]   m_even_q;

  logic [DataWidth-1:0]   hbuf [MaximumSideSize];
  logic [DataWidth-1:0]   ebuf [MaximumSideSize];

  // Handshake: a beat moves when valid and ready are both high at a rising
  // edge. The whole pipeline advances together, only when the output register
  // is empty or being drained, so m_valid_o/m_data_o hold while m_ready_i=0.
  assign adv        = !m_valid_q || m_ready_i;
  assign s_ready_o  = rst_i && adv && (state_q != FLUSH);
  assign acc        = s_valid_i && s_ready_o;
  assign h_in       = s_data_i[2*DataWidth-1:DataWidth];
  assign l_in       = s_data_i[DataWidth-1:0];
  assign restart    = acc && s_sof_i;
  assign in_beat    = acc && !s_sof_i && !drop_q && (state_q == FIRST || state_q == STEADY);
  assign beat       = restart || in_beat;
  assign first_beat = restart || (state_q == FIRST);
  assign flush_beat = adv && (state_q == FLUSH);
  assign beat_col_d = restart ? '0 : col_q;
  assign line_end   = s_eol_i || (state_q == STEADY && col_q == last_col_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      col_q      <= '0;
      last_col_q <= '0;
      drop_q     <= 1'b0;
      sof_pend_q <= 1'b0;
    end else begin
      if (adv && s1_emit) sof_pend_q <= 1'b0;
      if (restart) begin
        sof_pend_q <= 1'b1;
        drop_q     <= 1'b0;
        if (s_eol_i) begin
          col_q      <= '0;
          last_col_q <= '0;
          state_q    <= s_eof_i ? FLUSH : STEADY;
        end else begin
          col_q   <= AddrWidth'(1);
          state_q <= FIRST;
        end
      end else begin
        case (state_q)
          FIRST: if (in_beat) begin
            if (s_eol_i) begin
              last_col_q <= col_q;
              col_q      <= '0;
              state_q    <= s_eof_i ? FLUSH : STEADY;
            end else begin
              col_q <= col_q + AddrWidth'(1);
            end
          end
          STEADY: if (acc && drop_q) begin
            if (s_eol_i) drop_q <= 1'b0;
          end else if (in_beat) begin
            // A line running past the latched width ends early; the tail is dropped.
            if (line_end) begin
              col_q  <= '0;
              drop_q <= !s_eol_i;
              if (s_eof_i) state_q <= FLUSH;
            end else begin
              col_q <= col_q + AddrWidth'(1);
            end
          end
          FLUSH: if (adv) begin
            if (col_q == last_col_q) begin
              col_q   <= '0;
              state_q <= IDLE;
            end else begin
              col_q <= col_q + AddrWidth'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_flush_q <= 1'b0;
      s1_col_q   <= '0;
      s1_l_q     <= '0;
      s1_h_q     <= '0;
    end else if (adv) begin
      s1_valid_q <= beat || flush_beat;
      s1_first_q <= beat && first_beat;
      s1_flush_q <= flush_beat;
      s1_col_q   <= beat_col_d;
      s1_l_q     <= l_in;
      s1_h_q     <= h_in;
    end
  end

  // Line buffers: read-first on Hbuf; Ebuf forwards the even sample being
  // written this edge so back-to-back rows of a narrow frame see fresh data.
  always_ff @(posedge clk_i) begin
    if (adv && beat) hbuf[beat_col_d] <= h_in;
    if (e_we) ebuf[s1_col_q] <= x_even;
    if (adv) begin
      hprev_q <= hbuf[beat_col_d];
      eprev_q <= (e_we && s1_col_q == beat_col_d) ? x_even : ebuf[beat_col_d];
    end
  end

  assign s1_emit = s1_valid_q && !s1_first_q;
  assign e_we    = adv && s1_valid_q && !s1_flush_q;
  assign even_b  = s1_first_q ? s1_h_q : hprev_q;
  assign odd_c   = s1_flush_q ? eprev_q : x_even;

  inverse_lifting_step #(
    .DataWidth(DataWidth), .Point(Point), .Coef(IntBeta), .Registered(1'b0)
  ) u_update (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b0),
    .a_i(s1_l_q), .b_i(even_b), .c_i(s1_h_q), .y_o(x_even)
  );

  inverse_lifting_step #(
    .DataWidth(DataWidth), .Point(Point), .Coef(IntAlpha), .Registered(1'b1)
  ) u_predict (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(adv && s1_emit),
    .a_i(hprev_q), .b_i(eprev_q), .c_i(odd_c), .y_o(m_odd)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_valid_q <= 1'b0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
      m_eof_q   <= 1'b0;
      m_even_q  <= '0;
    end else if (adv) begin
      m_valid_q <= s1_emit;
      if (s1_emit) begin
        m_even_q <= eprev_q;
        m_sof_q  <= sof_pend_q;
        m_eol_q  <= (s1_col_q == last_col_q);
        m_eof_q  <= s1_flush_q;
      end
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_sof_o   = m_sof_q;
  assign m_eol_o   = m_eol_q;
  assign m_eof_o   = m_eof_q;
  assign m_data_o  = {m_odd, m_even_q};

endmodule

// File: tb/tb_inverse_processing_unit_1d.sv
// Directed bench for the inverse column lifting unit with an expected-beat queue.
module tb_inverse_processing_unit_1d;
  import inverse_processing_unit_1d_pkg::*;

  localparam int DW = 16;
  localparam int IA = -1624;  // round(-1.586134342 * 1024)
  localparam int IB = -54;    // round(-0.052980118 * 1024)

  logic            clk_i, rst_i;
  logic            s_ready_o, s_valid_i, s_sof_i, s_eol_i, s_eof_i;
  logic [2*DW-1:0] s_data_i;
  logic            m_ready_i, m_valid_o, m_sof_o, m_eol_o, m_eof_o;
  logic [2*DW-1:0] m_data_o;

  int checks = 0;
  int errors = 0;
  logic [2*DW+2:0] exp_q[$];
  logic [DW-1:0]   fh [4][4];
  logic [DW-1:0]   fl [4][4];
  logic            toggle_en = 1'b0;
  logic            hold_pend = 1'b0;
  logic [2*DW-1:0] hold_data = '0;

  inverse_processing_unit_1d dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_ready_o(s_ready_o), .s_valid_i(s_valid_i), .s_sof_i(s_sof_i),
    .s_eol_i(s_eol_i), .s_eof_i(s_eof_i), .s_data_i(s_data_i),
    .m_ready_i(m_ready_i), .m_valid_o(m_valid_o), .m_sof_o(m_sof_o),
    .m_eol_o(m_eol_o), .m_eof_o(m_eof_o), .m_data_o(m_data_o)
  );

  // Clock and output-ready driver
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      m_ready_i = toggle_en ? ~m_ready_i : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] lift(logic [DW-1:0] a, logic [DW-1:0] b,
                                         logic [DW-1:0] c, int k);
    logic signed [DW-1:0] s;
    longint p;
    s = b + c;
    p = (longint'(k) * longint'(s)) >>> 10;
    return a - p[DW-1:0];
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Golden model: whole-sample symmetric extension at top and bottom.
  task automatic push_model(int rows, int w);
    logic [DW-1:0] ev [5][4];
    logic [DW-1:0] hm1, od;
    for (int n = 0; n < rows; n++)
      for (int c = 0; c < w; c++) begin
        hm1 = (n == 0) ? fh[0][c] : fh[n-1][c];
        ev[n][c] = lift(fl[n][c], hm1, fh[n][c], IB);
      end
    for (int c = 0; c < w; c++) ev[rows][c] = ev[rows-1][c];
    for (int n = 0; n < rows; n++)
      for (int c = 0; c < w; c++) begin
        od = lift(fh[n][c], ev[n][c], ev[n+1][c], IA);
        exp_q.push_back({od, ev[n][c], (n == 0 && c == 0), (c == w - 1), (n == rows - 1)});
      end
  endtask

  task automatic send_beat(logic [DW-1:0] h, logic [DW-1:0] l, logic sof, logic eol, logic eof);
    int guard;
    logic ok;
    guard = 0;
    ok = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = {h, l};
    s_sof_i   = sof;
    s_eol_i   = eol;
    s_eof_i   = eof;
    while (guard < 200) begin
      @(negedge clk_i);
      if (s_ready_o) begin
        ok = 1'b1;
        break;
      end
      guard++;
    end
    check("beat_accept", 64'(ok), 64'd1);
    @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    s_eof_i   = 1'b0;
  endtask

  task automatic send_frame(int rows, int w);
    for (int n = 0; n < rows; n++)
      for (int c = 0; c < w; c++)
        send_beat(fh[n][c], fl[n][c], (n == 0 && c == 0), (c == w - 1), (n == rows - 1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0) break;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic fill_random(int rows, int w);
    for (int n = 0; n < rows; n++)
      for (int c = 0; c < w; c++) begin
        fh[n][c] = DW'($urandom_range(0, 65535));
        fl[n][c] = DW'($urandom_range(0, 65535));
      end
  endtask

  // Scoreboard: compare each consumed beat, and hold stability under stall.
  always @(negedge clk_i) begin
    logic [2*DW+2:0] e;
    if (hold_pend) begin
      checks++;
      assert (m_valid_o === 1'b1 && m_data_o === hold_data) else begin
        errors++;
        $error("FAIL stall_hold observed=%b/%h expected=1/%h", m_valid_o, m_data_o, hold_data);
      end
    end
    hold_pend = m_valid_o && !m_ready_i && rst_i;
    hold_data = m_data_o;
    if (m_valid_o === 1'b1 && m_ready_i) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed=%h expected=none", m_data_o);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({m_data_o, m_sof_o, m_eol_o, m_eof_o} === e) else begin
          errors++;
          $error("FAIL out_beat observed=%h/%b%b%b expected=%h/%b%b%b",
                 m_data_o, m_sof_o, m_eol_o, m_eof_o, e[2*DW+2:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    rst_i     = 1'b0;
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    s_eof_i   = 1'b0;
    s_data_i  = '0;
    repeat (3) @(negedge clk_i);
    check("rst_s_ready", 64'(s_ready_o), 64'd0);
    check("rst_m_valid", 64'(m_valid_o), 64'd0);
    check("rst_m_data", 64'(m_data_o), 64'd0);
    check("rst_flags", 64'({m_sof_o, m_eol_o, m_eof_o}), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // Width 1, two rows, L=1024 H=0
    fh[0][0] = 16'd0;    fl[0][0] = 16'd1024;
    fh[1][0] = 16'd0;    fl[1][0] = 16'd1024;
    exp_q.push_back({16'd3248, 16'd1024, 1'b1, 1'b1, 1'b0});
    exp_q.push_back({16'd3248, 16'd1024, 1'b0, 1'b1, 1'b1});
    send_frame(2, 1);
    wait_drain();

    // Width 1, two rows, L=0 H=1024: floor shift and symmetric extension
    fh[0][0] = 16'd1024; fl[0][0] = 16'd0;
    fh[1][0] = 16'd1024; fl[1][0] = 16'd0;
    exp_q.push_back({16'd1367, 16'd108, 1'b1, 1'b1, 1'b0});
    exp_q.push_back({16'd1367, 16'd108, 1'b0, 1'b1, 1'b1});
    send_frame(2, 1);
    wait_drain();

    // Width 4, three random rows; input blocked during the 4 flush cycles
    fill_random(3, 4);
    push_model(3, 4);
    send_frame(3, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("flush_s_ready", 64'(s_ready_o), 64'd0);
    end
    @(negedge clk_i);
    check("idle_s_ready", 64'(s_ready_o), 64'd1);
    wait_drain();

    // Same frame with output back-pressure every other cycle
    toggle_en = 1'b1;
    push_model(3, 4);
    send_frame(3, 4);
    wait_drain();
    toggle_en = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset during the second row, then a fresh width-2 single-row frame
    fill_random(2, 4);
    for (int c = 0; c < 4; c++) send_beat(fh[0][c], fl[0][c], (c == 0), (c == 3), 1'b0);
    send_beat(fh[1][0], fl[1][0], 1'b0, 1'b0, 1'b0);
    send_beat(fh[1][1], fl[1][1], 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("midrst_m_valid", 64'(m_valid_o), 64'd0);
    check("midrst_s_ready", 64'(s_ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("postrst_m_valid", 64'(m_valid_o), 64'd0);
    @(posedge clk_i);
    #1;
    fh[0][0] = 16'd0; fl[0][0] = 16'd1024;
    fh[0][1] = 16'd0; fl[0][1] = 16'd1024;
    exp_q.push_back({16'd3248, 16'd1024, 1'b1, 1'b0, 1'b1});
    exp_q.push_back({16'd3248, 16'd1024, 1'b0, 1'b1, 1'b1});
    send_frame(1, 2);
    wait_drain();

    // Single-row random frame: flush-only output, back to IDLE
    fill_random(1, 3);
    push_model(1, 3);
    send_frame(1, 3);
    wait_drain();
    repeat (2) @(negedge clk_i);
    check("end_state_idle", 64'(dut.state_q), 64'(IDLE));
    check("end_m_valid", 64'(m_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inverse_processing_unit_1d.md
Name: inverse_processing_unit_1d

Overview:
- Inverse 9/7 lifting slice for the column (vertical) direction; the mirror of the forward column processing unit.
- Input: stream of {high, low} coefficient pairs, one pair per column, one row-pair per line.
- Undoes update (Beta) then predict (Alpha) with per-column line buffers and whole-sample symmetric extension at the frame top and bottom.
- Output: reconstructed {odd, even} sample pairs, one row-pair behind the input, plus a flush row after the last input row.

Parameters:
- DataWidth, 16, signed fixed-point word width
- Point, 10, fractional bits
- MaximumSideSize, 512, max columns per line; buffer depth; AddrWidth = $clog2(MaximumSideSize)
- Alpha, Coefficient::Alpha, predict coefficient (real)
- Beta, Coefficient::Beta, update coefficient (real)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-low
- s_ready_o  out  1  input ready
- s_valid_i  in  1  input valid
- s_sof_i  in  1  first beat of frame
- s_eol_i  in  1  last beat of line
- s_eof_i  in  1  asserted on every beat of the last input line
- s_data_i  in  2*DataWidth  {H (high/odd), L (low/even)}
- m_ready_i  in  1  output ready
- m_valid_o  out  1  output valid
- m_sof_o  out  1  first output beat of frame
- m_eol_o  out  1  last beat of output line
- m_eof_o  out  1  beats of last output line
- m_data_o  out  2*DataWidth  {x_odd, x_even}

Behaviour:
- Reset (rst_i=0, async): s_ready_o=0, m_valid_o=0, m_sof_o=m_eol_o=m_eof_o=0, m_data_o=0; FSM enters IDLE; column counter, width register and line buffers are invalid.
- Transfer rules:
  - Input beat accepted when s_valid_i & s_ready_o.
  - Output beat consumed when m_valid_o & m_ready_i.
  - m_valid_o and m_data_o hold while m_ready_i=0.
  - s_ready_o = (!m_valid_o | m_ready_i) & state in {IDLE, FIRST, STEADY}.
- Arithmetic:
  - IntAlpha = round(Alpha*2^Point); IntBeta = round(Beta*2^Point).
  - Products are full precision, arithmetic shift right by Point (floor).
  - Sums and differences wrap at DataWidth; there is no saturation.
- Per row-pair n and column c: x_even[n] = L[n] - Beta*(H[n-1] + H[n]); x_odd[n] = H[n] - Alpha*(x_even[n] + x_even[n+1]).
- Line buffers (two simple dual-port BRAMs, 1-cycle read, indexed by column counter):
  - Hbuf stores H[n].
  - Ebuf stores x_even[n] and is paired with Hbuf for the deferred odd computation.
- FSM:
  - IDLE: wait for an accepted beat with s_sof_i. Beats without sof are accepted and dropped. Goes to FIRST.
  - FIRST (row 0): H[-1] := H[0] (symmetric). Compute x_even[0]; write Hbuf/Ebuf; produce no output. Width W latched from the column count at s_eol_i. On eol go to STEADY, or to FLUSH if s_eof_i.
  - STEADY (row n >= 1):
    - Read Hbuf/Ebuf[c]; compute x_even[n] and x_odd[n-1].
    - Emit {x_odd[n-1], x_even[n-1]}; write H[n] and x_even[n].
    - Column count reaching W without s_eol_i: the eol is forced and the counter wraps. Excess beats before eol are dropped.
    - On eol with s_eof_i go to FLUSH.
  - FLUSH: s_ready_o=0. Generate W internal beats with x_even[N] := x_even[N-1] (symmetric). Emit the last row with m_eof_o=1 and m_eol_o on beat W-1, then go to IDLE.
- Output flags:
  - m_sof_o on the first emitted beat of the frame.
  - m_eol_o on column W-1.
- Latency: an accepted STEADY beat at cycle t is presented at t+2 when m_ready_i stays 1. FLUSH emits one beat per cycle under the same condition.
- Boundary cases:
  - Single-row frame (sof and eof on row 0): FLUSH alone emits row 0 using H[-1]=H[0] and x_even[1]=x_even[0].
  - s_sof_i mid-frame: the current frame is abandoned and FIRST restarts at column 0.
  - Reset mid-frame: clears all state and drops any output in flight.

Decomposition:
- The package coefficient_pkg holds:
  - IntAlpha/IntBeta conversion functions
  - the state enum {IDLE, FIRST, STEADY, FLUSH}
  - the fixed-point multiply-shift function
- Reuse the existing Bram, Adder, Multiplyer, Counter and Dffenr blocks.
- One natural sub-module: inverse_lifting_step, the combinational out = a - k*(b + c) with a pipeline register. It is instantiated for both steps.

Test Plan:
- Width 1, two rows, L=1024, H=0 (Point=10, default coefficients) -> two output beats {3248, 1024}; the second has m_eof_o=1 and m_eol_o=1; the first has m_sof_o=1.
- Width 1, two rows, L=0, H=1024 -> outputs {1367, 108} both rows; checks the floor shift and symmetric extension.
- Width 4, three rows of random data vs a golden model -> 12 output beats matching bit-exactly. m_eol_o on each 4th beat; s_ready_o=0 for the 4 FLUSH cycles.
- Same stimulus with m_ready_i toggling 1/0 every cycle -> identical data sequence; no beat dropped or duplicated; m_data_o stable while stalled.
- Reset asserted during the second row, then a fresh width-2 single-row frame L=1024, H=0 -> no stale output after reset; two beats {3248, 1024} with m_sof_o on the first.
- Single-row frame with sof and eof on all beats -> FLUSH-only output matches the symmetric formula; FSM returns to IDLE.
